// File: rtl/sha256_digest_writer.sv
// Writes a captured 256-bit SHA-256 digest out as eight 32-bit words (H0 first) with a ready handshake.
// Define SHA256_DIGEST_WRITER_BYTE_SWAP_EN to present each word byte-reversed on write_data.
module sha256_digest_writer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [255:0]          digest_in,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic                  mem_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [31:0]           write_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [255:0]          digest_q, digest_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Word i sits at bit offset (7-i)*32; ~i equals 7-i for a 3-bit index.
  function automatic logic [31:0] word_at(input logic [255:0] d, input logic [2:0] i);
    logic [31:0] w;
    w = d[{~i, 5'b0} +: 32];
`ifdef SHA256_DIGEST_WRITER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    digest_d = digest_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          digest_d = digest_in;
          idx_d    = 3'd0;
          addr_d   = base_address;
          data_d   = word_at(digest_in, 3'd0);
          we_d     = 1'b1;
          busy_d   = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (we_q && mem_ready) begin
          if (idx_q == 3'd7) begin
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 3'd1;
            addr_d = addr_q + ADDR_WIDTH'(1);
            data_d = word_at(digest_q, idx_q + 3'd1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      digest_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      digest_q <= digest_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sha256_digest_writer.sv
// Self-checking bench for sha256_digest_writer: vector table, hand sequences and random backpressure.
module tb_sha256_digest_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [255:0] digest_in = '0;
  logic [15:0]  base_address = '0;
  logic         mem_ready = 1'b0;
  logic         write_enable;
  logic [15:0]  write_address;
  logic [31:0]  write_data;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] ABC = {32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                                  32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};

  sha256_digest_writer #(.ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .digest_in(digest_in),
    .base_address(base_address), .mem_ready(mem_ready), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [255:0] dg;
    logic [15:0]  base;
    logic [31:0]  rdy;
    int           exp_done;
  } vec_t;

  vec_t vecs[3];

  // Reference word k of a digest as it should appear on the bus.
  function automatic logic [31:0] ref_word(input logic [255:0] dg, input int k);
    logic [31:0] w;
    w = dg[255 - 32*k -: 32];
`ifdef SHA256_DIGEST_WRITER_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  // Done arrives the cycle after the eighth cycle in which memory was ready.
  function automatic int ref_done_cycle(input logic [31:0] rdy);
    int acc = 0;
    for (int c = 1; c < 32; c++) begin
      if (rdy[c]) acc++;
      if (acc == 8) return c + 1;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [63:0] bus();
    return {13'd0, write_enable, busy, done, write_address, write_data};
  endfunction

  // Cycle 0 asserts start; checks every cycle through the done pulse.
  task automatic run_seq(input logic [255:0] dg, input logic [15:0] base, input logic [31:0] rdy,
                         input int exp_done, input int restart_c, input int chg_c);
    int  k = 0;
    bit  fin = 0;
    logic [63:0] exp;
    for (int c = 0; c < 32 && !fin; c++) begin
      @(posedge clock); #1;
      start = (c == 0) || (c == restart_c);
      if (c == 0) begin digest_in = dg; base_address = base; end
      if (c == chg_c) digest_in = '1;
      mem_ready = rdy[c];
      @(negedge clock);
      if (c == 0) begin
        check("idle_before_start", {61'd0, write_enable, busy, done}, 64'd0);
      end else begin
        if (k < 8) exp = {13'd0, 3'b110, 16'(base + 16'(k)), ref_word(dg, k)};
        else       exp = {13'd0, 3'b001, 16'(base + 16'd7), ref_word(dg, 7)};
        check("beat", bus(), exp);
        if (k == 8) begin
          fin = 1;
          check("done_cycle", 64'(c), 64'(exp_done));
        end else if (rdy[c]) begin
          k++;
        end
      end
    end
    start = 1'b0;
    if (!fin) check("sequence_timeout", 64'(k), 64'd9);
  endtask

  initial begin
    vecs[0] = '{ABC, 16'h0100, 32'hFFFF_FFFF, 9};
    vecs[1] = '{ABC, 16'h0100, 32'hFFFF_FFC7, 12};
    vecs[2] = '{ABC, 16'hFFFE, 32'hFFFF_FFFF, 9};

    #2;
    check("reset_outputs", bus(), 64'd0);
    @(negedge clock); reset = 1'b1;

    for (int i = 0; i < 3; i++)
      run_seq(vecs[i].dg, vecs[i].base, vecs[i].rdy, vecs[i].exp_done, -1, -1);

    // Ignored restart and digest_in change, then a back-to-back start at cycle 10.
    run_seq(ABC, 16'h0100, 32'hFFFF_FFFF, 9, 4, 2);
    run_seq({256{1'b1}}, 16'h0100, 32'hFFFF_FFFF, 9, -1, -1);

    // Asynchronous reset in the middle of a sequence.
    @(posedge clock); #1;
    start = 1'b1; digest_in = ABC; base_address = 16'h0100; mem_ready = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    #3; reset = 1'b0; #1;
    check("reset_mid_sequence", bus(), 64'd0);
    @(posedge clock); #1;
    check("reset_held_no_done", bus(), 64'd0);
    @(negedge clock); reset = 1'b1;
    run_seq(ABC, 16'h0100, 32'hFFFF_FFFF, 9, -1, -1);

    // Random digests, bases and backpressure against the reference model.
    for (int t = 0; t < 8; t++) begin
      logic [255:0] dg;
      logic [31:0]  rdy;
      logic [15:0]  base;
      for (int w = 0; w < 8; w++) dg[32*w +: 32] = $urandom;
      base = 16'($urandom);
      rdy  = $urandom | 32'hFFF0_0000;
      run_seq(dg, base, rdy, ref_done_cycle(rdy), -1, -1);
    end

    @(posedge clock); #1;
    @(negedge clock);
    check("final_idle", {61'd0, write_enable, busy, done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
